// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment display path: digit geometry,
// reset values, decoder code points and the display-word bundle.
package seg_pkg;

  localparam int DIGITS = 8;
  localparam int CODE_W = 4;
  localparam int IDX_W  = $clog2(DIGITS);
  localparam int WORD_W = DIGITS * CODE_W;

  localparam logic [DIGITS-1:0] LED_EN_RST  = '1;
  localparam logic [CODE_W-1:0] NUM_SET_RST = '0;

  // Code points understood by the segment decoder in both glyph sets.
  localparam logic [CODE_W-1:0] CODE_DIGIT_0 = 4'h0;
  localparam logic [CODE_W-1:0] CODE_DIGIT_9 = 4'h9;
  localparam logic [CODE_W-1:0] DASH_CODE    = 4'hA;
  localparam logic [CODE_W-1:0] ERR_CODE     = 4'hB;
  localparam logic [CODE_W-1:0] BLANK_CODE   = 4'hE;

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic [DIGITS-1:0] mask;
    logic              boom;
  } disp_word_t;

  localparam disp_word_t DISP_WORD_RST = '0;

  // Active-low enable vector: at most the selected digit is driven low.
  function automatic logic [DIGITS-1:0] digit_enable(
    input logic [IDX_W-1:0]  idx,
    input logic [DIGITS-1:0] mask,
    input logic              off
  );
    logic [DIGITS-1:0] en;
    en = LED_EN_RST;
    if (mask[idx] && !off) en[idx] = 1'b0;
    return en;
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running prescaler: one-cycle tick every SCAN_DIV clocks, on the last count
// of each period. Shared by the display scanner and the keypad debouncer.
module scan_tick_gen #(
  parameter int SCAN_DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] div_cnt;

  assign tick = (div_cnt == LAST);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; reset here is synchronous and wins over counting.
  always_ff @(posedge clk) begin
    if (rst)       div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 1'b1;
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Eight-digit time-multiplexed scan driver with frame-synchronous double
// buffering and whole-display blink while the alarm flag is displayed.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int SCAN_DIV     = 100000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WORD_W-1:0] data_in,
  input  logic [DIGITS-1:0] digit_mask,
  input  logic              boom_in,
  output logic [CODE_W-1:0] num_set,
  output logic              boom1,
  output logic [DIGITS-1:0] led_en,
  output logic              frame_done
);

  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BW-1:0]    BLINK_LAST = BW'(BLINK_FRAMES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

  logic              tick;
  logic              frame_end;
  logic [IDX_W-1:0]  idx;
  disp_word_t        shadow;
  disp_word_t        disp;
  logic [BW-1:0]     blink_cnt;
  logic              blink_off;
  logic [CODE_W-1:0] num_nxt;
  logic [DIGITS-1:0] led_nxt;

  scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign frame_end = tick && (idx == IDX_LAST);

  always_ff @(posedge clk) begin
    if (rst)       idx <= '0;
    else if (tick) idx <= idx + 1'b1;
  end

  // Last load in a frame wins; the display only ever sees a complete word.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= DISP_WORD_RST;
    end else if (load) begin
      shadow <= '{data: data_in, mask: digit_mask, boom: boom_in};
    end
  end

  // A load in the boundary cycle lands in shadow too late for this copy.
  always_ff @(posedge clk) begin
    if (rst)            disp <= DISP_WORD_RST;
    else if (frame_end) disp <= shadow;
  end

  // Blink phase advances only across boundaries where the alarm stays shown,
  // so the first alarm frame is always lit and leaving alarm clears at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt <= '0;
      blink_off <= 1'b0;
    end else if (frame_end) begin
      if (!shadow.boom) begin
        blink_cnt <= '0;
        blink_off <= 1'b0;
      end else if (disp.boom) begin
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt <= '0;
          blink_off <= ~blink_off;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

  // NOTE: combinational blocks assign every output unconditionally so no
  // latch can be inferred.
  always_comb begin
    num_nxt = disp.data[int'(idx) * CODE_W +: CODE_W];
    led_nxt = digit_enable(idx, disp.mask, blink_off);
  end

  // Code and enable share one register stage so they always switch together.
  always_ff @(posedge clk) begin
    if (rst) begin
      num_set    <= NUM_SET_RST;
      boom1      <= 1'b0;
      led_en     <= LED_EN_RST;
      frame_done <= 1'b0;
    end else begin
      num_set    <= num_nxt;
      boom1      <= disp.boom;
      led_en     <= led_nxt;
      frame_done <= frame_end;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: directed scenarios plus random loads,
// compared every cycle against a frame/slot arithmetic reference model.
module tb_seg_scan_ctrl;
  import seg_pkg::*;

  localparam int SD    = 4;
  localparam int BF    = 2;
  localparam int FRAME = 8 * SD;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [31:0] data_in;
  logic [7:0]  digit_mask;
  logic        boom_in;
  logic [3:0]  num_set;
  logic        boom1;
  logic [7:0]  led_en;
  logic        frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .data_in    (data_in),
    .digit_mask (digit_mask),
    .boom_in    (boom_in),
    .num_set    (num_set),
    .boom1      (boom1),
    .led_en     (led_en),
    .frame_done (frame_done)
  );

  // Reference model: cyc counts clock edges since reset release; slot and frame
  // position follow from it arithmetically.
  int unsigned cyc;
  logic [31:0] m_sh_data, m_dp_data;
  logic [7:0]  m_sh_mask, m_dp_mask;
  logic        m_sh_boom, m_dp_boom;
  int          alarm_frame;
  logic [3:0]  e_num;
  logic        e_boom1;
  logic [7:0]  e_led;
  logic        e_fd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic ld, input logic [31:0] d,
                      input logic [7:0] m, input logic b);
    int idx;
    bit last;
    bit off;
    rst = r; load = ld; data_in = d; digit_mask = m; boom_in = b;
    @(posedge clk);
    if (r) begin
      cyc = 0; alarm_frame = 0;
      m_sh_data = '0; m_sh_mask = '0; m_sh_boom = 1'b0;
      m_dp_data = '0; m_dp_mask = '0; m_dp_boom = 1'b0;
      e_num = 4'h0; e_boom1 = 1'b0; e_led = 8'hFF; e_fd = 1'b0;
    end else begin
      idx  = (cyc / SD) % 8;
      last = (cyc % FRAME) == FRAME - 1;
      off  = m_dp_boom && (((alarm_frame / BF) % 2) == 1);
      e_num   = m_dp_data[idx*4 +: 4];
      e_boom1 = m_dp_boom;
      e_led   = 8'hFF;
      if (m_dp_mask[idx] && !off) e_led[idx] = 1'b0;
      e_fd    = last;
      if (last) begin
        alarm_frame = (m_dp_boom && m_sh_boom) ? alarm_frame + 1 : 0;
        m_dp_data = m_sh_data; m_dp_mask = m_sh_mask; m_dp_boom = m_sh_boom;
      end
      if (ld) begin
        m_sh_data = d; m_sh_mask = m; m_sh_boom = b;
      end
      cyc++;
    end
    #1;
    check("num_set", {28'b0, num_set}, {28'b0, e_num});
    check("boom1", {31'b0, boom1}, {31'b0, e_boom1});
    check("led_en", {24'b0, led_en}, {24'b0, e_led});
    check("frame_done", {31'b0, frame_done}, {31'b0, e_fd});
    check("led_one_low", {31'b0, ($countones(~led_en) <= 1)}, 32'd1);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 1'b0, $urandom, 8'($urandom), 1'($urandom));
  endtask

  task automatic do_load(input logic [31:0] d, input logic [7:0] m, input logic b);
    step(1'b0, 1'b1, d, m, b);
  endtask

  // Advance until the next clock edge falls at frame position p.
  task automatic wait_phase(input int p);
    while ((cyc % FRAME) != p) idle(1);
  endtask

  initial begin
    int fd_cnt;
    rst = 1'b1; load = 1'b0; data_in = '0; digit_mask = '0; boom_in = 1'b0;
    cyc = 0;

    // Reset and blank idle display
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, '0, 1'b0);
    check("rst_led_en", {24'b0, led_en}, 32'h0000_00FF);
    check("rst_num_set", {28'b0, num_set}, 32'd0);
    idle(2 * FRAME);

    // Scan order
    do_load(32'h8765_4321, 8'hFF, 1'b0);
    wait_phase(0);
    fd_cnt = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      idle(1);
      fd_cnt += int'(frame_done);
    end
    check("frame_done_count", fd_cnt, 32'd2);

    // No tearing: load zeros while digit 3 is up
    wait_phase(3 * SD + 1);
    do_load(32'h0, 8'hFF, 1'b0);
    idle(2 * FRAME);

    // Load coinciding with the frame boundary
    do_load(32'h1357_9BDF, 8'hFF, 1'b0);
    wait_phase(FRAME - 1);
    do_load(32'hA5A5_5A5A, 8'hFF, 1'b0);
    idle(3 * FRAME);

    // Repeated loads within a frame, then blanking
    do_load(32'hFFFF_FFFF, 8'hAA, 1'b0);
    idle(5);
    do_load(32'h1234_5678, 8'b0000_0101, 1'b0);
    idle(3 * FRAME);

    // Alarm blink, then leave alarm
    do_load(32'h8765_4321, 8'hFF, 1'b1);
    idle(8 * FRAME);
    do_load(32'h8765_4321, 8'hFF, 1'b0);
    idle(3 * FRAME);

    // Reset mid-frame discards pending shadow data
    do_load(32'hDEAD_BEEF, 8'hFF, 1'b1);
    wait_phase(5 * SD + 2);
    step(1'b1, 1'b0, '0, '0, 1'b0);
    step(1'b1, 1'b0, '0, '0, 1'b0);
    idle(2 * FRAME);

    // Random loads and occasional resets
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(499) == 0)
        step(1'b1, 1'b0, '0, '0, 1'b0);
      else if ($urandom_range(19) == 0)
        do_load($urandom, 8'($urandom), ($urandom_range(1) == 1));
      else
        idle(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
